// File: rtl/clause_vote_accumulator_pkg.sv
// Shared types and helpers for the clause vote accumulator slice.
// Holds the FSM state encoding, default sizing, and the saturating adder used on class sums.
package tm_acc_pkg;

   localparam int unsigned N_PE_COL_DEF  = 5;
   localparam int unsigned N_ELEMENT_DEF = 4;
   localparam int unsigned N_LANE_DEF    = N_PE_COL_DEF * N_ELEMENT_DEF;
   localparam int unsigned N_CLASS_DEF   = 12;
   localparam int unsigned SUM_WIDTH_DEF = 12;
   localparam int unsigned CLASS_W_DEF   = $clog2(N_CLASS_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } acc_state_e;

   // Adds a and d, then clamps the result to the signed range of a w-bit register.
   function automatic int sat_add(input int a, input int d, input int unsigned w);
      int s;
      int hi;
      int lo;
      s  = a + d;
      hi = (1 <<< (w - 1)) - 1;
      lo = -(1 <<< (w - 1));
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/clause_vote_accumulator_if.sv
// Lane-result input and prediction output bundle of the clause vote accumulator.
// The master side is the PE array plus the system controller; the slave side is the accumulator.
interface clause_vote_accumulator_if
   import tm_acc_pkg::*;
#(
   parameter int unsigned N_LANE    = N_LANE_DEF,
   parameter int unsigned CLASS_W   = CLASS_W_DEF,
   parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF
);

   logic                                result_valid;
   logic                                result_last;
   logic [N_LANE-1:0]                   patch0_result;
   logic [N_LANE-1:0]                   patch1_result;
   logic [N_LANE-1:0]                   lane_en;
   logic [N_LANE-1:0][CLASS_W-1:0]      lane_class;
   logic                                accum_ready;
   logic                                pred_valid;
   logic                                pred_ready;
   logic [CLASS_W-1:0]                  pred_class;
   logic signed [SUM_WIDTH-1:0]         pred_sum;

   modport master (
      output result_valid, result_last, patch0_result, patch1_result, lane_en, lane_class,
      output pred_ready,
      input  accum_ready, pred_valid, pred_class, pred_sum
   );

   modport slave (
      input  result_valid, result_last, patch0_result, patch1_result, lane_en, lane_class,
      input  pred_ready,
      output accum_ready, pred_valid, pred_class, pred_sum
   );

endinterface

// File: rtl/clause_vote_accumulator_class_delta.sv
// Combinational per-class vote delta: positive patch0 hits minus patch1 hits for each class.
// Disabled lanes and lanes tagged with an out-of-range class contribute nothing.
module class_delta
   import tm_acc_pkg::*;
#(
   parameter int unsigned N_LANE  = N_LANE_DEF,
   parameter int unsigned N_CLASS = N_CLASS_DEF,
   parameter int unsigned CLASS_W = CLASS_W_DEF,
   parameter int unsigned DELTA_W = $clog2(N_LANE) + 2
) (
   input  logic [N_LANE-1:0]              patch0_i,
   input  logic [N_LANE-1:0]              patch1_i,
   input  logic [N_LANE-1:0]              lane_en_i,
   input  logic [N_LANE-1:0][CLASS_W-1:0] lane_class_i,
   output logic signed [DELTA_W-1:0]      delta_o [N_CLASS]
);

   logic [DELTA_W-1:0] pos;
   logic [DELTA_W-1:0] neg;

   always_comb begin
      pos = '0;
      neg = '0;
      for (int unsigned c = 0; c < N_CLASS; c++) begin
         pos = '0;
         neg = '0;
         for (int unsigned l = 0; l < N_LANE; l++) begin
            if (lane_en_i[l] && (lane_class_i[l] == CLASS_W'(c))) begin
               pos = pos + DELTA_W'(patch0_i[l]);
               neg = neg + DELTA_W'(patch1_i[l]);
            end
         end
         delta_o[c] = $signed(pos - neg);
      end
   end

endmodule

// File: rtl/clause_vote_accumulator.sv
// Accumulates signed per-class clause votes over an inference and reports the arg-max class.
// Arg-max is a sequential scan, one class per cycle, with ties resolved to the lowest index.
module clause_vote_accumulator
   import tm_acc_pkg::*;
#(
   parameter int unsigned N_PE_COL  = N_PE_COL_DEF,
   parameter int unsigned N_ELEMENT = N_ELEMENT_DEF,
   parameter int unsigned N_CLASS   = N_CLASS_DEF,
   parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF,
   parameter int unsigned CLASS_W   = $clog2(N_CLASS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   clause_vote_accumulator_if.slave    acc_bus
);

   localparam int unsigned N_LANE  = N_ELEMENT * N_PE_COL;
   localparam int unsigned DELTA_W = $clog2(N_LANE) + 2;

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_ACCUM  = ST_ACCUM;
   localparam logic [1:0] S_ARGMAX = ST_ARGMAX;
   localparam logic [1:0] S_DONE   = ST_DONE;

   logic [1:0]                  state_q, state_d;
   logic signed [SUM_WIDTH-1:0] sum_q [N_CLASS];
   logic signed [SUM_WIDTH-1:0] sum_d [N_CLASS];
   logic [CLASS_W-1:0]          idx_q, idx_d;
   logic [CLASS_W-1:0]          best_idx_q, best_idx_d;
   logic signed [SUM_WIDTH-1:0] best_sum_q, best_sum_d;
   logic [CLASS_W-1:0]          pred_class_q, pred_class_d;
   logic signed [SUM_WIDTH-1:0] pred_sum_q, pred_sum_d;
   logic                        pred_valid_q, pred_valid_d;

   logic signed [DELTA_W-1:0]   delta [N_CLASS];
   logic                        accum_ready;
   logic                        accept;
   logic signed [SUM_WIDTH-1:0] scan_sum;
   logic                        scan_better;

   class_delta #(
      .N_LANE  (N_LANE),
      .N_CLASS (N_CLASS),
      .CLASS_W (CLASS_W),
      .DELTA_W (DELTA_W)
   ) u_class_delta (
      .patch0_i     (acc_bus.patch0_result),
      .patch1_i     (acc_bus.patch1_result),
      .lane_en_i    (acc_bus.lane_en),
      .lane_class_i (acc_bus.lane_class),
      .delta_o      (delta)
   );

   assign accum_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
   assign accept      = acc_bus.result_valid && accum_ready;

   // Index 0 always seeds best; afterwards only a strictly larger sum replaces it.
   assign scan_sum    = sum_q[idx_q];
   assign scan_better = (idx_q == '0) || (scan_sum > best_sum_q);

   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      idx_d        = idx_q;
      best_idx_d   = best_idx_q;
      best_sum_d   = best_sum_q;
      pred_class_d = pred_class_q;
      pred_sum_d   = pred_sum_q;
      pred_valid_d = pred_valid_q;

      if (clear) begin
         state_d      = S_IDLE;
         idx_d        = '0;
         pred_valid_d = 1'b0;
         for (int unsigned c = 0; c < N_CLASS; c++) sum_d[c] = '0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (accept) begin
                  for (int unsigned c = 0; c < N_CLASS; c++)
                     sum_d[c] = SUM_WIDTH'(sat_add(int'(sum_q[c]), int'(delta[c]), SUM_WIDTH));
                  idx_d   = '0;
                  state_d = acc_bus.result_last ? S_ARGMAX : S_ACCUM;
               end
            end
            S_ARGMAX: begin
               if (scan_better) begin
                  best_idx_d = idx_q;
                  best_sum_d = scan_sum;
               end
               if (idx_q == CLASS_W'(N_CLASS - 1)) begin
                  state_d      = S_DONE;
                  pred_class_d = scan_better ? idx_q : best_idx_q;
                  pred_sum_d   = scan_better ? scan_sum : best_sum_q;
                  pred_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            S_DONE: begin
               if (acc_bus.pred_ready) begin
                  state_d      = S_IDLE;
                  pred_valid_d = 1'b0;
                  for (int unsigned c = 0; c < N_CLASS; c++) sum_d[c] = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         best_idx_q   <= '0;
         best_sum_q   <= '0;
         pred_class_q <= '0;
         pred_sum_q   <= '0;
         pred_valid_q <= 1'b0;
         for (int unsigned c = 0; c < N_CLASS; c++) sum_q[c] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         best_idx_q   <= best_idx_d;
         best_sum_q   <= best_sum_d;
         pred_class_q <= pred_class_d;
         pred_sum_q   <= pred_sum_d;
         pred_valid_q <= pred_valid_d;
         for (int unsigned c = 0; c < N_CLASS; c++) sum_q[c] <= sum_d[c];
      end
   end

   assign acc_bus.accum_ready = accum_ready;
   assign acc_bus.pred_valid  = pred_valid_q;
   assign acc_bus.pred_class  = pred_class_q;
   assign acc_bus.pred_sum    = pred_sum_q;

endmodule
